// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD-to-decimal scan decoder: latches an N-digit packed BCD word and
// shows one digit at a time (LSD first) as a one-hot decimal plus one-hot digit select.
module bcd_scan_decoder #(
    parameter int N_DIGITS   = 4,
    parameter int DWELL      = 3,
    parameter int CONTINUOUS = 0,
    parameter int LZ_BLANK   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] in_bcd,
    output logic [9:0]            dec_out,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic                  scan_active,
    output logic                  frame_done,
    output logic                  err_invalid
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                     state, n_state;
    logic [IW-1:0]              idx, n_idx;
    logic [DW-1:0]              dwell, n_dwell;
    logic [N_DIGITS-1:0][3:0]   word, n_word;
    logic                       hs, last, n_clr;
    logic [N_DIGITS:0]          zero_up;
    logic [3:0]                 n_digit;
    logic                       n_bad, n_blank, n_last;

    assign last     = (idx == IW'(N_DIGITS - 1)) && (dwell == DW'(DWELL - 1));
    assign in_ready = !rst && ((state == IDLE) || ((CONTINUOUS != 0) && (state == SCAN) && last));
    assign hs       = in_valid && in_ready;

    always_comb begin
        n_state = state;
        n_idx   = idx;
        n_dwell = dwell;
        n_word  = word;
        n_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    n_state = SCAN;
                    n_idx   = '0;
                    n_dwell = '0;
                    n_word  = in_bcd;
                    n_clr   = 1'b1;
                end
            end
            default: begin
                if (last) begin
                    n_idx   = '0;
                    n_dwell = '0;
                    if (CONTINUOUS == 0) begin
                        n_state = IDLE;
                    end else if (hs) begin
                        n_word = in_bcd;
                        n_clr  = 1'b1;
                    end
                end else if (dwell == DW'(DWELL - 1)) begin
                    n_dwell = '0;
                    n_idx   = idx + 1'b1;
                end else begin
                    n_dwell = dwell + 1'b1;
                end
            end
        endcase
    end

    // zero_up[k]: digit k and every more-significant digit are literal zeros
    always_comb begin
        zero_up           = '0;
        zero_up[N_DIGITS] = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--)
            zero_up[k] = zero_up[k+1] && (n_word[k] == 4'd0);
    end

    assign n_digit = n_word[n_idx];
    assign n_bad   = (n_digit > 4'd9);
    assign n_blank = (LZ_BLANK != 0) && (n_idx != '0) && zero_up[int'(n_idx)];
    assign n_last  = (n_idx == IW'(N_DIGITS - 1)) && (n_dwell == DW'(DWELL - 1));

    // Outputs are registered from the next-state view so they line up with idx/dwell
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dwell       <= '0;
            word        <= '0;
            dec_out     <= '0;
            digit_sel   <= '0;
            scan_active <= 1'b0;
            frame_done  <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            state <= n_state;
            idx   <= n_idx;
            dwell <= n_dwell;
            word  <= n_word;
            if (n_state == SCAN) begin
                scan_active <= 1'b1;
                digit_sel   <= N_DIGITS'(1) << n_idx;
                dec_out     <= (n_bad || n_blank) ? 10'd0 : (10'd1 << n_digit);
                frame_done  <= n_last;
                err_invalid <= (n_clr ? 1'b0 : err_invalid) | n_bad;
            end else begin
                scan_active <= 1'b0;
                digit_sel   <= '0;
                dec_out     <= '0;
                frame_done  <= 1'b0;
            end
        end
    end
endmodule
